// File: rtl/branch_pkg.sv
// Shared types for the program-flow controller:
// branch condition codes and run/halt states.
package branch_pkg;

   typedef enum logic [2:0] {
      C_ALWAYS = 3'b000,
      C_EQ     = 3'b001,
      C_NE     = 3'b010,
      C_LT     = 3'b011,
      C_GE     = 3'b100,
      C_CS     = 3'b101,
      C_CC     = 3'b110,
      C_NEVER  = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether a conditional
// branch is taken from the registered z/n/c flags.
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic       z,
   input  logic       n,
   input  logic       c,
   output logic       take
);

   cond_e cond;

   assign cond = cond_e'(br_cond);

   always_comb begin
      take = 1'b0;
      unique case (cond)
         C_ALWAYS: take = 1'b1;
         C_EQ:     take = z;
         C_NE:     take = !z;
         C_LT:     take = n;
         C_GE:     take = !n;
         C_CS:     take = c;
         C_CC:     take = !c;
         C_NEVER:  take = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctl.sv
// Program-flow controller: flag register, program counter,
// run/halt FSM and saturating taken-branch counter.
module branch_ctl
   import branch_pkg::*;
#(
   parameter int PC_W  = 10,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic             stall,
   input  logic             flag_we,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             c_in,
   input  logic             br_valid,
   input  logic [2:0]       br_cond,
   input  logic [PC_W-1:0]  br_target,
   input  logic             halt_req,
   output logic [PC_W-1:0]  pc,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             done,
   output logic [CNT_W-1:0] taken_cnt
);

   state_e state;
   logic   take;

   // Evaluated on the registered flags, so a same-cycle
   // flag write is not seen by the branch.
   branch_cond u_cond (
      .br_cond (br_cond),
      .z       (z),
      .n       (n),
      .c       (c),
      .take    (take)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         pc        <= '0;
         z         <= 1'b0;
         n         <= 1'b0;
         c         <= 1'b0;
         done      <= 1'b0;
         taken_cnt <= '0;
      end else begin
         if (flag_we) begin
            z <= z_in;
            n <= n_in;
            c <= c_in;
         end
         unique case (state)
            IDLE: begin
               pc   <= '0;
               done <= 1'b0;
               if (start) begin
                  state     <= RUN;
                  taken_cnt <= '0;
               end
            end
            RUN: begin
               if (!stall) begin
                  if (halt_req) begin
                     state <= HALT;
                     done  <= 1'b1;
                  end else if (br_valid && take) begin
                     pc <= br_target;
                     if (taken_cnt != '1)
                        taken_cnt <= taken_cnt + 1'b1;
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            HALT: begin
               if (start) begin
                  state     <= RUN;
                  pc        <= '0;
                  done      <= 1'b0;
                  taken_cnt <= '0;
               end
            end
            default: begin
               state <= IDLE;
               pc    <= '0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
